spi_master_fifo: RTL and testbench

//  Byte-oriented SPI master with small TX/RX FIFOs. It is the peripheral behind the
//  SPI_* ports of the sensor applications (e.g. the MAX6682 mean-value FSM).
//  The application pushes dummy/command bytes and watches Transmission_o fall.
//  It then pops the received bytes. Mode (CPOL/CPHA/LSB-first) and SCK rate are

---
 rtl/spi_master_fifo_if.sv | 30 +++
 rtl/spi_master_fifo.sv | 154 +++++++++++++++
 tb/tb_spi_master_fifo.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_fifo_if.sv
// Signal bundle between the sensor application and the SPI master FIFO peripheral,
// including the SPI pins. Signal names match the peripheral's original port list.
interface spi_master_fifo_if #(
  parameter int DIV_WIDTH = 8
);
  logic                 CPOL_i;
  logic                 CPHA_i;
  logic                 LSBFE_i;
  logic [DIV_WIDTH-1:0] ClkDiv_i;
  logic [7:0]           Data_i;
  logic                 Write_i;
  logic                 ReadNext_i;
  logic [7:0]           Data_o;
  logic                 FIFOFull_o;
  logic                 FIFOEmpty_o;
  logic                 Transmission_o;
  logic                 SCK_o;
  logic                 MOSI_o;
  logic                 MISO_i;

  modport slave (
    input  CPOL_i, CPHA_i, LSBFE_i, ClkDiv_i, Data_i, Write_i, ReadNext_i, MISO_i,
    output Data_o, FIFOFull_o, FIFOEmpty_o, Transmission_o, SCK_o, MOSI_o
  );

  modport master (
    output CPOL_i, CPHA_i, LSBFE_i, ClkDiv_i, Data_i, Write_i, ReadNext_i, MISO_i,
    input  Data_o, FIFOFull_o, FIFOEmpty_o, Transmission_o, SCK_o, MOSI_o
  );
endinterface

// File: rtl/spi_master_fifo.sv
// Byte-oriented SPI master with TX/RX FIFOs; mode and SCK rate are latched per byte.
module spi_master_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int DIV_WIDTH       = 8
) (
  input logic              Clk_i,
  input logic              Reset_n_i,
  spi_master_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [PW-1:0] tx_wr_d, tx_rd_d, rx_wr_d, rx_rd_d;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, rx_push, rx_pop;
  logic [7:0]    tx_head, rx_head_d;

  logic                 cpha_q, lsbfe_q;
  logic [DIV_WIDTH-1:0] div_q, div_cnt_q;
  logic [4:0]           tog_q;
  logic [7:0]           tx_sh_q, rx_sh_q;
  logic                 sck_q, mosi_q;
  logic [7:0]           data_q;
  logic                 full_q, empty_q, trans_q;
  logic                 load, tick, byte_done, odd_tog, do_sample, do_shift;

  function automatic logic ptr_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
    return (wr[PW-1] != rd[PW-1]) && (wr[PW-2:0] == rd[PW-2:0]);
  endfunction

  always_comb begin
    tx_empty = (tx_wr_q == tx_rd_q);
    tx_full  = ptr_full(tx_wr_q, tx_rd_q);
    rx_empty = (rx_wr_q == rx_rd_q);
    rx_full  = ptr_full(rx_wr_q, rx_rd_q);
    tx_head  = tx_mem[tx_rd_q[PW-2:0]];
    tx_push  = bus.Write_i && !tx_full;
    rx_pop   = bus.ReadNext_i && !rx_empty;
    // a pop in the completing cycle frees the slot, so a full RX still accepts the byte
    rx_push  = byte_done && (!rx_full || rx_pop);
    tx_wr_d  = tx_wr_q + PW'(tx_push);
    tx_rd_d  = tx_rd_q + PW'(load);
    rx_wr_d  = rx_wr_q + PW'(rx_push);
    rx_rd_d  = rx_rd_q + PW'(rx_pop);
    if (rx_push && (rx_wr_q[PW-2:0] == rx_rd_d[PW-2:0])) rx_head_d = rx_sh_q;
    else                                                   rx_head_d = rx_mem[rx_rd_d[PW-2:0]];
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!tx_empty) state_d = SHIFT;
      SHIFT:   if (tick && (tog_q == 5'd15)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // toggles are numbered tog_q+1, so an even tog_q means an odd toggle is due
  always_comb begin
    load      = 1'b0;
    tick      = 1'b0;
    byte_done = 1'b0;
    unique case (state_q)
      IDLE:    load      = !tx_empty;
      SHIFT:   tick      = (div_cnt_q == div_q);
      DONE:    byte_done = 1'b1;
      default: ;
    endcase
    odd_tog   = ~tog_q[0];
    do_sample = tick && (cpha_q ? ~odd_tog : odd_tog);
    do_shift  = tick && (cpha_q ? odd_tog : (~odd_tog && (tog_q != 5'd15)));
  end

  always_ff @(posedge Clk_i) begin
    if (tx_push) tx_mem[tx_wr_q[PW-2:0]] <= bus.Data_i;
    if (rx_push) rx_mem[rx_wr_q[PW-2:0]] <= rx_sh_q;
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      cpha_q    <= 1'b0;
      lsbfe_q   <= 1'b0;
      div_q     <= '0;
      div_cnt_q <= '0;
      tog_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      data_q    <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      trans_q   <= 1'b0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      full_q  <= ptr_full(tx_wr_d, tx_rd_d);
      empty_q <= (rx_wr_d == rx_rd_d);
      trans_q <= (tx_wr_d != tx_rd_d) || (state_d != IDLE);
      data_q  <= rx_head_d;
      if (state_q == IDLE) sck_q <= bus.CPOL_i;
      if (load) begin
        cpha_q    <= bus.CPHA_i;
        lsbfe_q   <= bus.LSBFE_i;
        div_q     <= bus.ClkDiv_i;
        div_cnt_q <= '0;
        tog_q     <= '0;
        if (bus.CPHA_i) begin
          tx_sh_q <= tx_head;
        end else begin
          mosi_q  <= bus.LSBFE_i ? tx_head[0] : tx_head[7];
          tx_sh_q <= bus.LSBFE_i ? {1'b0, tx_head[7:1]} : {tx_head[6:0], 1'b0};
        end
      end else if (tick) begin
        div_cnt_q <= '0;
        sck_q     <= ~sck_q;
        tog_q     <= tog_q + 5'd1;
      end else if (state_q == SHIFT) begin
        div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
      end
      if (do_shift) begin
        mosi_q  <= lsbfe_q ? tx_sh_q[0] : tx_sh_q[7];
        tx_sh_q <= lsbfe_q ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
      end
      if (do_sample)
        rx_sh_q <= lsbfe_q ? {bus.MISO_i, rx_sh_q[7:1]} : {rx_sh_q[6:0], bus.MISO_i};
    end
  end

  assign bus.SCK_o          = sck_q;
  assign bus.MOSI_o         = mosi_q;
  assign bus.Data_o         = data_q;
  assign bus.FIFOFull_o     = full_q;
  assign bus.FIFOEmpty_o    = empty_q;
  assign bus.Transmission_o = trans_q;
endmodule

// File: tb/tb_spi_master_fifo.sv
// Bench for spi_master_fifo: mode table plus FIFO-full, overflow and reset-abort sequences,
// with an SPI slave model that checks each shifted-out byte against a queue of expected bytes.
module tb_spi_master_fifo;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_fifo_if #(.DIV_WIDTH(8)) bus ();

  spi_master_fifo #(.FIFO_DEPTH_LOG2(2), .DIV_WIDTH(8)) dut (
    .Clk_i     (clk),
    .Reset_n_i (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [7:0] div;
    logic [7:0] tx;
    logic       lpbk;
    logic [7:0] ret;
    logic [7:0] exp_rx;
    logic       exp_idle;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  mosi_exp [$];
  bit          cur_cpha, cur_lsb, loop_en;
  int unsigned cur_div;
  logic [7:0]  ret_byte = '0;
  logic        slave_bit = 1'b0;
  int unsigned ret_next = 0;
  int unsigned sck_changes = 0;

  assign bus.MISO_i = loop_en ? bus.MOSI_o : slave_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ret_bit(input logic [7:0] b, input bit lsb, input int unsigned idx);
    return lsb ? b[idx] : b[7-idx];
  endfunction

  // SPI slave model: captures MOSI on sample edges, drives MISO on change edges
  logic        sck_prev = 1'b0;
  int unsigned tog = 0;
  int unsigned clk_since = 0;
  logic [7:0]  cap = '0;
  bit          hp_ok = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      tog = 0; clk_since = 0; hp_ok = 1'b1;
    end else begin
      if (bus.SCK_o != sck_prev) sck_changes++;
      if (mosi_exp.size() == 0) begin
        tog = 0; clk_since = 0; hp_ok = 1'b1;
      end else begin
        clk_since++;
        if (bus.SCK_o != sck_prev) begin
          tog++;
          if (tog > 1 && clk_since != cur_div + 1) hp_ok = 1'b0;
          clk_since = 0;
          if (cur_cpha ? (tog % 2 == 0) : (tog % 2 == 1))
            cap = cur_lsb ? {bus.MOSI_o, cap[7:1]} : {cap[6:0], bus.MOSI_o};
          if ((cur_cpha ? (tog % 2 == 1) : (tog % 2 == 0 && tog < 16)) && ret_next < 8) begin
            slave_bit = ret_bit(ret_byte, cur_lsb, ret_next);
            ret_next++;
          end
          if (tog == 16) begin
            check("mosi_byte", cap, mosi_exp.pop_front());
            check("sck_half_period", hp_ok, 1);
            tog = 0; hp_ok = 1'b1;
          end
        end
      end
    end
    sck_prev = bus.SCK_o;
  end

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsb, input logic [7:0] div);
    bus.CPOL_i = cpol; bus.CPHA_i = cpha; bus.LSBFE_i = lsb; bus.ClkDiv_i = div;
    cur_cpha = cpha; cur_lsb = lsb; cur_div = div;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    bus.Data_i = b; bus.Write_i = 1'b1;
    @(negedge clk);
    bus.Write_i = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned k;
    k = 0;
    while (bus.Transmission_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("trans_fall", bus.Transmission_o, 0);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, bus.Data_o, exp);
    bus.ReadNext_i = 1'b1;
    @(negedge clk);
    bus.ReadNext_i = 1'b0;
  endtask

  task automatic count_edges(input int unsigned target, output int unsigned n);
    logic prev;
    prev = bus.SCK_o;
    n = 0;
    for (int k = 0; k < 400 && n < target; k++) begin
      @(negedge clk);
      if (bus.SCK_o != prev) n++;
      prev = bus.SCK_o;
    end
  endtask

  initial begin
    vec_t        vt [4];
    int unsigned base, n;

    vt[0] = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 1'b1, 8'h00, 8'hA5, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 8'd3, 8'h81, 1'b0, 8'h3C, 8'h3C, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 8'd1, 8'h5C, 1'b0, 8'hC3, 8'hC3, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b1, 8'd2, 8'h96, 1'b1, 8'h00, 8'h96, 1'b1};

    loop_en = 1'b1;
    bus.Write_i = 1'b0; bus.ReadNext_i = 1'b0; bus.Data_i = '0;
    bus.CPOL_i = 1'b0; bus.CPHA_i = 1'b0; bus.LSBFE_i = 1'b0; bus.ClkDiv_i = '0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.CPOL_i = 1'($urandom_range(0, 1)); bus.CPHA_i = 1'($urandom_range(0, 1));
      bus.LSBFE_i = 1'($urandom_range(0, 1)); bus.ClkDiv_i = 8'($urandom_range(0, 255));
      bus.Data_i = 8'($urandom_range(0, 255)); bus.Write_i = 1'($urandom_range(0, 1));
      bus.ReadNext_i = 1'($urandom_range(0, 1));
      #1;
      check("rst_sck", bus.SCK_o, 0);
      check("rst_empty", bus.FIFOEmpty_o, 1);
      check("rst_full", bus.FIFOFull_o, 0);
      check("rst_trans", bus.Transmission_o, 0);
      check("rst_data", bus.Data_o, 0);
    end
    @(negedge clk);
    bus.Write_i = 1'b0; bus.ReadNext_i = 1'b0; bus.CPOL_i = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("sck_takes_cpol", bus.SCK_o, 1);

    // single-byte transfers across modes
    for (int i = 0; i < 4; i++) begin
      set_mode(vt[i].cpol, vt[i].cpha, vt[i].lsbfe, vt[i].div);
      check("idle_sck", bus.SCK_o, vt[i].exp_idle);
      loop_en = vt[i].lpbk; ret_byte = vt[i].ret;
      if (!vt[i].cpha) begin
        slave_bit = ret_bit(vt[i].ret, vt[i].lsbfe, 0); ret_next = 1;
      end else begin
        ret_next = 0;
      end
      mosi_exp.push_back(vt[i].tx);
      write_byte(vt[i].tx);
      check("trans_rise", bus.Transmission_o, 1);
      wait_done(2000);
      check("rx_data", bus.Data_o, vt[i].exp_rx);
      check("rx_nonempty", bus.FIFOEmpty_o, 0);
      check("sck_back_idle", bus.SCK_o, vt[i].exp_idle);
      check("mosi_consumed", mosi_exp.size(), 0);
      pop_check("rx_pop", vt[i].exp_rx);
      check("rx_empty_after_pop", bus.FIFOEmpty_o, 1);
    end
    loop_en = 1'b1;

    // TX full: six back-to-back writes, sixth dropped
    set_mode(1'b0, 1'b0, 1'b0, 8'd15);
    base = sck_changes;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) check("tx_full_flag", bus.FIFOFull_o, (i == 6));
      bus.Data_i = 8'(i); bus.Write_i = 1'b1;
      if (i <= 5) mosi_exp.push_back(8'(i));
      @(negedge clk);
    end
    bus.Write_i = 1'b0;
    check("tx_full_after_drop", bus.FIFOFull_o, 1);
    wait_done(10000);
    check("sck_edges_five_bytes", sck_changes - base, 80);
    check("mosi_consumed_full", mosi_exp.size(), 0);
    for (int i = 1; i <= 4; i++) pop_check("drain_full", 8'(i));
    check("drain_full_empty", bus.FIFOEmpty_o, 1);

    // RX overflow: fifth byte discarded, stored bytes intact
    set_mode(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      bus.Data_i = 8'h10 + 8'(i); bus.Write_i = 1'b1;
      mosi_exp.push_back(8'h10 + 8'(i));
      @(negedge clk);
    end
    bus.Write_i = 1'b0;
    wait_done(2000);
    check("ovf_nonempty", bus.FIFOEmpty_o, 0);
    for (int i = 0; i < 4; i++) pop_check("ovf_pop", 8'h10 + 8'(i));
    check("ovf_empty", bus.FIFOEmpty_o, 1);

    // pop in the same cycle a byte completes into a full RX
    for (int i = 0; i < 4; i++) begin
      bus.Data_i = 8'h20 + 8'(i); bus.Write_i = 1'b1;
      mosi_exp.push_back(8'h20 + 8'(i));
      @(negedge clk);
    end
    bus.Write_i = 1'b0;
    wait_done(2000);
    mosi_exp.push_back(8'h24);
    write_byte(8'h24);
    count_edges(16, n);
    check("edges_before_pop", n, 16);
    pop_check("head_at_collision", 8'h20);
    wait_done(100);
    for (int i = 1; i <= 4; i++) pop_check("collision_pop", 8'h20 + 8'(i));
    check("collision_empty", bus.FIFOEmpty_o, 1);

    // asynchronous reset during toggle 5
    set_mode(1'b0, 1'b0, 1'b0, 8'd3);
    mosi_exp.push_back(8'h77);
    write_byte(8'h77);
    count_edges(5, n);
    check("edges_before_reset", n, 5);
    check("pre_reset_sck", bus.SCK_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sck", bus.SCK_o, 0);
    check("abort_mosi", bus.MOSI_o, 0);
    check("abort_trans", bus.Transmission_o, 0);
    check("abort_empty", bus.FIFOEmpty_o, 1);
    check("abort_full", bus.FIFOFull_o, 0);
    check("abort_data", bus.Data_o, 0);
    @(negedge clk);
    mosi_exp.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mosi_exp.push_back(8'h5A);
    write_byte(8'h5A);
    wait_done(2000);
    check("post_reset_data", bus.Data_o, 8'h5A);
    check("post_reset_nonempty", bus.FIFOEmpty_o, 0);
    check("post_reset_mosi", mosi_exp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
